keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Reads a 4x4 matrix keypad (Pmod KYPD) on the board. It drives the column lines one at a time and samples the row lines, much as the seven-segment driver scans its anodes. Each new key press is debounced, encoded to a 4-bit hex code, and signalled with a one-cycle strobe. Its output replaces the slide switches as the operand source for the multiplier path.

Parameters:
- SCAN_DIV, 100000: clock cycles per column slot (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive full scans needed to accept a press or a release; must be >= 1.
- REPEAT_SCANS, 250: full scans between auto-repeat strobes; used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clock_100Mhz  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  keypad row lines; active-low, pulled up on the board; asynchronous to the clock.
- col  output  4  keypad column drive; exactly one bit is low at any time.
- key_code  output  4  hex code of the last accepted key; holds its value until the next accept.
- key_valid  output  1  one-cycle strobe when key_code is updated by a press.
- key_down  output  1  high while the accepted key is considered held.

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_down=0, FSM=IDLE, all counters 0.
- row passes through a 2-flop synchronizer before any use.
- Slot timer:
  - Counts 0..SCAN_DIV-1 and then wraps.
  - On wrap, col rotates one step low-bit-first: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Row sampling:
  - Synchronized rows are sampled only on the last cycle of each slot, giving SCAN_DIV-1 cycles of settling.
  - Per-scan hit logic: the first low row seen in the scan wins. Priority is lower column index first, then lower row index; any other pressed keys are ignored.
  - scan_hit and scan_code are evaluated at the end of the col3 slot, then cleared for the next scan.
- Key map (row, col -> code):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- FSM, evaluated once per scan end:
  - IDLE:
    - scan_hit -> go to CONFIRM; cand=scan_code; cnt=1.
    - If DEBOUNCE_SCANS==1, accept immediately (same actions as the accept below).
  - CONFIRM:
    - scan_hit with scan_code==cand -> cnt++.
    - When cnt reaches DEBOUNCE_SCANS, accept: key_code=cand, key_valid=1 for one cycle, key_down=1, go to HELD, cnt=0.
    - scan_hit with a different code -> restart CONFIRM with the new cand, cnt=1.
    - No hit -> go to IDLE.
  - HELD:
    - Any scan_hit (same or other key) -> cnt=0.
    - No hit -> cnt++; when cnt reaches DEBOUNCE_SCANS, key_down=0 and go to IDLE.
    - A second key pressed while held produces no strobe until a full release.
- Latency: a row held stable from a slot boundary produces key_valid within (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles.
- key_valid is registered and is never high on two consecutive cycles.
- Reset mid-operation clears everything asynchronously. Scanning restarts at col0 on the first clock after deassertion.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- When defined: in HELD, a scan counter runs while the accepted key (code==key_code) stays detected. Every REPEAT_SCANS scans it re-pulses key_valid with key_code unchanged. The counter clears on any scan that misses that key.
- When undefined: the counter and its logic are absent, REPEAT_SCANS is ignored, and exactly one strobe is produced per press.

Decomposition:
- Package keypad_pkg holds:
  - the FSM state encoding (IDLE, CONFIRM, HELD);
  - KEYMAP, a 16-entry constant indexed {row,col} -> code;
  - COL_INIT = 4'b1110.
- One sub-module, keypad_sync2: a 4-bit two-flop synchronizer with async active-low reset.
- Slot timer, column rotator and FSM stay inside keypad_scanner.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3; one scan = 16 cycles. The row model pulls row[r] low while col[c] is low for the pressed key.
- Reset and idle scan: assert reset, release, no key -> col=1110 right after reset, then cycles 1110, 1101, 1011, 0111 every 4 clocks; key_valid and key_down stay 0 for 200 cycles.
- Single press: hold key (row1,col2) -> exactly one key_valid pulse with key_code=4'h6 within 51 cycles, key_down=1. Release -> key_down falls after 2 empty scans, with no further strobe.
- Bounce rejection: press (row3,col0) for only 1 scan, then release -> no key_valid and key_code stays 0. Then a stable press of the same key -> key_code=4'h0 accepted with one strobe.
- Priority and held lockout:
  - Press (row0,col3) and (row2,col1) together -> key_code=4'h8 (lower column wins).
  - While held, add (row0,col0) -> no new strobe.
  - Release all, then press (row0,col0) alone -> key_code=4'h1.
- Reset mid-operation: assert reset while in CONFIRM -> all outputs 0 and col=1110 immediately. After release the press is re-debounced from scratch.
- With KEYPAD_REPEAT_EN defined: hold (row3,col3) for 12 scans -> first strobe with key_code=4'hD, then repeat strobes every 48 cycles with the code unchanged. Without the macro -> exactly 1 strobe.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   kp_state_e : debounce FSM states
//   KEYMAP     : 16-entry key code table indexed by {row[1:0], col[1:0]}
//   COL_INIT   : column drive after reset (col0 driven low)
package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConfirm,
    StHeld
  } kp_state_e;

  // Entry [r*4+c] is the hex code printed on the key at row r, column c.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
  localparam logic [15:0][3:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  localparam logic [3:0] COL_INIT = 4'b1110;

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key event bundle produced by the keypad scanner.
//   key_code  : hex code of the last accepted key (held until the next accept)
//   key_valid : one-cycle strobe when key_code is (re)issued
//   key_down  : high while the accepted key is considered held
// Modports: master (scanner side, drives), slave (consumer side, observes).
interface keypad_scanner_if;

  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_down
  );

endinterface

// File: rtl/keypad_sync2.sv
// keypad_sync2: 4-bit two-flop synchronizer for the asynchronous keypad rows.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (both stages load ResetVal)
//   d_i    : asynchronous input
//   q_o    : synchronized output
module keypad_sync2 #(
  parameter logic [3:0] ResetVal = 4'hF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time, debounces
// new presses over whole scans and reports them as a 4-bit hex code.
//   clock_100Mhz : system clock
//   reset        : asynchronous active-low reset
//   row          : keypad rows, active-low, asynchronous to the clock
//   col          : column drive, exactly one bit low
//   key          : key_code / key_valid / key_down (keypad_scanner_if master)
// Optional feature: define KEYPAD_REPEAT_EN to re-pulse key_valid every
// REPEAT_SCANS scans while the accepted key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 250
) (
  input  logic             clock_100Mhz,
  input  logic             reset,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  keypad_scanner_if.master key
);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : gen_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  localparam int unsigned       TimerW    = $clog2(SCAN_DIV);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(SCAN_DIV - 1);
  localparam int unsigned       CntW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0]   CntDone   = CntW'(DEBOUNCE_SCANS);
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned       RepW      = $clog2(REPEAT_SCANS + 1);
  localparam logic [RepW-1:0]   RepLast   = RepW'(REPEAT_SCANS - 1);
`endif

  logic [3:0] row_s;

  keypad_sync2 #(
    .ResetVal (4'hF)
  ) u_sync (
    .clk_i  (clock_100Mhz),
    .rst_ni (reset),
    .d_i    (row),
    .q_o    (row_s)
  );

  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        col_q, col_d;
  logic              hit_q, hit_d;
  logic [3:0]        code_q, code_d;
  kp_state_e         state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_down_q, key_down_d;
`ifdef KEYPAD_REPEAT_EN
  logic [RepW-1:0]   rep_q, rep_d;
`endif

  logic            slot_end;
  logic            scan_end;
  logic [1:0]      col_idx;
  logic [1:0]      samp_row;
  logic            samp_hit;
  logic [3:0]      samp_code;
  logic            scan_hit;
  logic [3:0]      scan_code;
  logic [CntW-1:0] cnt_inc;
  logic            accept;

  // Slot timer and column rotation (low bit first).
  assign slot_end = (timer_q == TimerLast);
  assign timer_d  = slot_end ? '0 : timer_q + 1'b1;
  assign col_d    = slot_end ? {col_q[2:0], col_q[3]} : col_q;

  always_comb begin
    col_idx = 2'd0;
    unique case (col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Lowest-index low row in the current column.
  always_comb begin
    samp_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) samp_row = 2'(i);
    end
  end

  assign samp_hit  = (row_s != 4'hF);
  assign samp_code = KEYMAP[{samp_row, col_idx}];
  assign scan_end  = slot_end && (col_idx == 2'd3);

  // Columns are visited low-first, so the first hit of a scan already has
  // the lowest column; later hits in the same scan are ignored.
  assign scan_hit  = hit_q | samp_hit;
  assign scan_code = hit_q ? code_q : samp_code;

  always_comb begin
    hit_d  = hit_q;
    code_d = code_q;
    if (scan_end) begin
      hit_d  = 1'b0;
      code_d = 4'h0;
    end else if (slot_end && !hit_q && samp_hit) begin
      hit_d  = 1'b1;
      code_d = samp_code;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // Debounce FSM; only advances on the last cycle of a full scan.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    accept      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (scan_hit) begin
            if (DEBOUNCE_SCANS == 1) begin
              accept = 1'b1;
            end else begin
              state_d = StConfirm;
              cand_d  = scan_code;
              cnt_d   = CntW'(1);
            end
          end
        end
        StConfirm: begin
          if (!scan_hit) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (scan_code != cand_q) begin
            cand_d = scan_code;
            cnt_d  = CntW'(1);
          end else if (cnt_inc == CntDone) begin
            accept = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHeld: begin
          if (scan_hit) begin
            cnt_d = '0;
          end else if (cnt_inc == CntDone) begin
            state_d    = StIdle;
            key_down_d = 1'b0;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
`ifdef KEYPAD_REPEAT_EN
          if (scan_hit && (scan_code == key_code_q)) begin
            if (rep_q == RepLast) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
        default: state_d = StIdle;
      endcase

      // On accept scan_code equals the candidate, so it is used directly.
      if (accept) begin
        key_code_d  = scan_code;
        key_valid_d = 1'b1;
        key_down_d  = 1'b1;
        state_d     = StHeld;
        cnt_d       = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = '0;
`endif
      end
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      timer_q     <= '0;
      col_q       <= COL_INIT;
      hit_q       <= 1'b0;
      code_q      <= 4'h0;
      state_q     <= StIdle;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      timer_q     <= timer_d;
      col_q       <= col_d;
      hit_q       <= hit_d;
      code_q      <= code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col           = col_q;
  assign key.key_code  = key_code_q;
  assign key.key_valid = key_valid_q;
  assign key.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated keypad matrix into keypad_scanner and
// checks every cycle against a scan-level behavioural model, plus directed
// literal checks for the main scenarios.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 2;
  localparam int unsigned RP = 3;
  localparam int          ScanCyc = 4 * SD;
`ifdef KEYPAD_REPEAT_EN
  localparam int          ExpHoldPulses = 4;
`else
  localparam int          ExpHoldPulses = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] pressed = 16'h0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB),
    .REPEAT_SCANS   (RP)
  ) dut (
    .clock_100Mhz (clk),
    .reset        (rst_n),
    .row          (row),
    .col          (col),
    .key          (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  int         e = 0;          // clock edges since reset release
  int         hist[$];        // last DB scan results, -1 = no key
  bit         m_held = 1'b0;
  logic [3:0] m_code = 4'h0;
  bit         m_valid = 1'b0;
  int         m_rep = 0;

  int         n_vec = 0;
  int         n_err = 0;
  int         pulses = 0;
  bit         chk_en = 1'b0;
  logic [3:0] exp_col;
  logic [3:0] col_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] v;
    v = 16'h0;
    v[r*4+c] = 1'b1;
    return v;
  endfunction

  // Winning key of a scan: lowest column, then lowest row.
  function automatic int scan_result(input logic [15:0] p);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (p[r*4+c]) return keymap[r*4+c];
    return -1;
  endfunction

  task automatic model_scan();
    int s;
    bit all_same;
    bit all_miss;
    s = scan_result(pressed);
    hist.push_back(s);
    if (hist.size() > DB) hist.delete(0);
    all_same = (hist.size() == DB) && (s >= 0);
    all_miss = (hist.size() == DB);
    foreach (hist[i]) begin
      if (hist[i] != s) all_same = 1'b0;
      if (hist[i] != -1) all_miss = 1'b0;
    end
    if (!m_held) begin
      if (all_same) begin
        m_held  = 1'b1;
        m_code  = 4'(s);
        m_valid = 1'b1;
        m_rep   = 0;
      end
    end else begin
      if (all_miss) m_held = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      if (s == int'(m_code)) begin
        m_rep++;
        if (m_rep == RP) begin
          m_valid = 1'b1;
          m_rep   = 0;
        end
      end else begin
        m_rep = 0;
      end
`endif
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e = 0;
      hist.delete();
      m_held  = 1'b0;
      m_code  = 4'h0;
      m_valid = 1'b0;
      m_rep   = 0;
    end else begin
      m_valid = 1'b0;
      if (e % ScanCyc == ScanCyc - 1) model_scan();
      e++;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      exp_col = 4'hF;
      exp_col[(e / SD) % 4] = 1'b0;
      cmp("col", col, exp_col);
      cmp("key_code", kif.key_code, m_code);
      cmp("key_valid", kif.key_valid, m_valid);
      cmp("key_down", kif.key_down, m_held);
      if (kif.key_valid === 1'b1) pulses++;
    end
  end

  task automatic scan_start();
    do begin
      @(posedge clk);
      #1;
    end while (e % ScanCyc != 0);
  endtask

  task automatic wait_scans(input int n);
    repeat (n) scan_start();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    bit seen;

    // Reset and idle scan.
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    cmp("reset_col", col, 4'b1110);
    cmp("reset_valid", kif.key_valid, 1'b0);
    cmp("reset_down", kif.key_down, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp("col_seq0", col, col_seq[0]);
    for (int k = 1; k <= 4; k++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      cmp("col_seq", col, col_seq[k % 4]);
    end
    repeat (184) @(negedge clk);
    cmp("idle_pulses", pulses, 0);
    cmp("idle_down", kif.key_down, 1'b0);

    // Single press of row1,col2 then release.
    scan_start();
    p0 = pulses;
    pressed = kbit(1, 2);
    wait_valid(51, seen);
    cmp("press_seen", seen, 1'b1);
    cmp("press_code", kif.key_code, 4'h6);
    cmp("press_down", kif.key_down, 1'b1);
    wait_scans(2);
    pressed = 16'h0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    cmp("release_down_hold", kif.key_down, 1'b1);
    @(negedge clk);
    cmp("release_down_fall", kif.key_down, 1'b0);
    cmp("press_pulses", pulses - p0, 1);

    // Bounce rejection on row3,col0.
    do_reset();
    scan_start();
    p0 = pulses;
    pressed = kbit(3, 0);
    wait_scans(1);
    pressed = 16'h0;
    wait_scans(3);
    cmp("bounce_pulses", pulses - p0, 0);
    cmp("bounce_code", kif.key_code, 4'h0);
    pressed = kbit(3, 0);
    wait_scans(3);
    @(negedge clk);
    cmp("stable_pulses", pulses - p0, 1);
    cmp("stable_code", kif.key_code, 4'h0);
    cmp("stable_down", kif.key_down, 1'b1);

    // Priority and held lockout.
    pressed = 16'h0;
    wait_scans(3);
    p0 = pulses;
    pressed = kbit(0, 3) | kbit(2, 1);
    wait_scans(3);
    cmp("prio_code", kif.key_code, 4'h8);
    cmp("prio_pulses", pulses - p0, 1);
    pressed = pressed | kbit(0, 0);
    wait_scans(3);
    cmp("lockout_pulses", pulses - p0, 1);
    cmp("lockout_code", kif.key_code, 4'h8);
    pressed = 16'h0;
    wait_scans(3);
    pressed = kbit(0, 0);
    wait_scans(3);
    cmp("after_code", kif.key_code, 4'h1);
    cmp("after_pulses", pulses - p0, 2);

    // Reset while in CONFIRM.
    pressed = 16'h0;
    wait_scans(3);
    pressed = kbit(1, 1);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    cmp("midrst_col", col, 4'b1110);
    cmp("midrst_code", kif.key_code, 4'h0);
    cmp("midrst_valid", kif.key_valid, 1'b0);
    cmp("midrst_down", kif.key_down, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (31) @(posedge clk);
    @(negedge clk);
    cmp("redeb_early_down", kif.key_down, 1'b0);
    @(negedge clk);
    cmp("redeb_code", kif.key_code, 4'h5);
    cmp("redeb_valid", kif.key_valid, 1'b1);

    // Long hold of row3,col3 (repeat strobes when enabled).
    scan_start();
    pressed = 16'h0;
    wait_scans(3);
    p0 = pulses;
    pressed = kbit(3, 3);
    wait_scans(12);
    cmp("hold_pulses", pulses - p0, ExpHoldPulses);
    cmp("hold_code", kif.key_code, 4'hD);

    // Randomized key sets held for random numbers of scans.
    pressed = 16'h0;
    wait_scans(3);
    for (int it = 0; it < 120; it++) begin
      if (it == 60) begin
        do_reset();
        scan_start();
      end
      case ($urandom_range(0, 3))
        0: pressed = 16'h0;
        1: pressed = kbit($urandom_range(0, 3), $urandom_range(0, 3));
        2: pressed = kbit($urandom_range(0, 3), $urandom_range(0, 3)) |
                     kbit($urandom_range(0, 3), $urandom_range(0, 3));
        default: pressed = pressed;
      endcase
      wait_scans($urandom_range(1, 4));
    end
    pressed = 16'h0;
    wait_scans(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
